// File: rtl/core_pkg.sv
// Shared definitions for the core control path.
// Holds the base opcode set (also used by the immediate generator), the
// sequencer state enum, instruction classes, and the wb_sel / trap_cause codes.
package core_pkg;

  // Base opcodes, instruction[6:0]
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ALUI   = 7'b0010011;
  localparam logic [6:0] OPC_ALU    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_LUI    = 4'd0,
    CLS_AUIPC  = 4'd1,
    CLS_JAL    = 4'd2,
    CLS_JALR   = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LOAD   = 4'd5,
    CLS_STORE  = 4'd6,
    CLS_ALUI   = 4'd7,
    CLS_ALU    = 4'd8,
    CLS_FENCE  = 4'd9
  } iclass_e;

  // Writeback mux select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Trap cause codes
  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO  = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO  = 2'd3;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decoder.
// Ports:
//   opcode - instruction[6:0]
//   iclass - instruction class (don't-care when legal=0)
//   legal  - 1 when opcode belongs to the supported base set
module opcode_classifier
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_e    iclass,
  output logic       legal
);

  // Map opcode to class; unknown opcodes are flagged illegal
  always_comb begin
    iclass = CLS_ALU;
    legal  = 1'b1;
    case (opcode)
      OPC_LUI:    iclass = CLS_LUI;
      OPC_AUIPC:  iclass = CLS_AUIPC;
      OPC_JAL:    iclass = CLS_JAL;
      OPC_JALR:   iclass = CLS_JALR;
      OPC_BRANCH: iclass = CLS_BRANCH;
      OPC_LOAD:   iclass = CLS_LOAD;
      OPC_STORE:  iclass = CLS_STORE;
      OPC_ALUI:   iclass = CLS_ALUI;
      OPC_ALU:    iclass = CLS_ALU;
      OPC_FENCE:  iclass = CLS_FENCE;
      default:    legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_control_fsm.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK].
// Drives datapath selects/enables from the class latched in DECODE, handshakes
// with instruction/data memory, and traps on illegal opcodes or ack timeouts.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   opcode, branch_taken       - from IR and branch comparator
//   imem_req/imem_ack, ir_we   - instruction fetch handshake, IR load
//   dmem_req/dmem_we/dmem_ack  - data access handshake
//   rf_we, pc_we, pc_sel       - register file / PC update controls
//   alu_a_sel, alu_b_sel       - ALU operand selects
//   wb_sel                     - writeback source
//   retire                     - one pulse per completed instruction
//   trap, trap_cause           - sticky fault flag and reason
module core_control_fsm
  import core_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_we,
  output logic       rf_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  // Count value at which the current non-ack cycle is the TIMEOUT-th wait
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  iclass_e          cls_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       cause_q;

  iclass_e          dec_cls_s;
  logic             dec_legal_s;
  logic             to_hit_s;
  logic [CNT_W-1:0] cnt_inc_s;

  opcode_classifier u_classifier (
    .opcode (opcode),
    .iclass (dec_cls_s),
    .legal  (dec_legal_s)
  );

  // An ack in the same cycle takes priority over this, so it only matters
  // when no ack arrives. TIMEOUT == 0 never expires.
  assign to_hit_s  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  // Saturate so a disabled timeout never wraps
  assign cnt_inc_s = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Sequencer state, latched class, wait counter and trap cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_ALU;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      // Counter clears on every transition; wait branches override below
      cnt_q <= '0;
      case (state_q)
        ST_FETCH: begin
          if (imem_ack) begin
            state_q <= ST_DECODE;
          end else if (to_hit_s) begin
            state_q <= ST_TRAP;
            cause_q <= CAUSE_IMEM_TO;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        ST_DECODE: begin
          cls_q <= dec_cls_s;
          if (dec_legal_s) begin
            state_q <= ST_EXECUTE;
          end else begin
            state_q <= ST_TRAP;
            cause_q <= CAUSE_ILLEGAL;
          end
        end
        ST_EXECUTE: begin
          case (cls_q)
            CLS_BRANCH, CLS_FENCE: state_q <= ST_FETCH;
            CLS_LOAD, CLS_STORE:   state_q <= ST_MEM;
            default:               state_q <= ST_WRITEBACK;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            state_q <= (cls_q == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
          end else if (to_hit_s) begin
            state_q <= ST_TRAP;
            cause_q <= CAUSE_DMEM_TO;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        ST_WRITEBACK: state_q <= ST_FETCH;
        ST_TRAP:      state_q <= ST_TRAP;
        default: begin
          // Corrupted state encoding is treated as a fault
          state_q <= ST_TRAP;
          cause_q <= CAUSE_ILLEGAL;
        end
      endcase
    end
  end

  // Datapath controls decoded from state, latched class and handshakes
  always_comb begin
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    wb_sel     = WB_ALU;
    retire     = 1'b0;
    trap       = 1'b0;
    trap_cause = cause_q;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      ST_DECODE: begin
        trap = 1'b0;
      end
      ST_EXECUTE: begin
        alu_a_sel = cls_q inside {CLS_AUIPC, CLS_JAL, CLS_BRANCH};
        alu_b_sel = (cls_q != CLS_ALU);
        if (cls_q == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken;
          retire = 1'b1;
        end else if (cls_q == CLS_FENCE) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end else begin
          pc_we = 1'b0;
        end
      end
      ST_MEM: begin
        // Operand selects held so the ALU-computed address stays stable
        alu_a_sel = cls_q inside {CLS_AUIPC, CLS_JAL, CLS_BRANCH};
        alu_b_sel = (cls_q != CLS_ALU);
        dmem_req  = 1'b1;
        dmem_we   = (cls_q == CLS_STORE);
        if (dmem_ack && (cls_q == CLS_STORE)) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end else begin
          pc_we = 1'b0;
        end
      end
      ST_WRITEBACK: begin
        // Selects held so the ALU result / jump target is valid here
        alu_a_sel = cls_q inside {CLS_AUIPC, CLS_JAL, CLS_BRANCH};
        alu_b_sel = (cls_q != CLS_ALU);
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        pc_sel    = cls_q inside {CLS_JAL, CLS_JALR};
        case (cls_q)
          CLS_LOAD:          wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
          CLS_LUI:           wb_sel = WB_IMM;
          default:           wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        trap = 1'b1;
      end
    endcase
    // Reset forces FETCH; keep its request low until reset is released
    if (!rst_n) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
    end else begin
      trap = trap;
    end
  end

endmodule

// File: tb/tb_core_control_fsm.sv
module tb_core_control_fsm;

  localparam int TO = 4;

  // Instruction kinds for the reference model
  localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BRANCH = 4;
  localparam int K_LOAD = 5, K_STORE = 6, K_ALUI = 7, K_ALU = 8, K_FENCE = 9, K_ILL = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0000000;
  logic       branch_taken = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel;
  logic       alu_a_sel, alu_b_sel, retire, trap;
  logic [1:0] wb_sel, trap_cause;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        ia;
    logic        da;
    logic [14:0] exp;
    string       tag;
  } step_t;

  step_t steps[$];

  logic [6:0] legal_ops [10];

  core_control_fsm #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .ir_we        (ir_we),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .wb_sel       (wb_sel),
    .retire       (retire),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  always #5 clk = ~clk;

  wire [14:0] act = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
                     alu_a_sel, alu_b_sel, wb_sel, retire, trap, trap_cause};

  function automatic logic [14:0] v(input logic imr, irw, dmr, dmw, rfw, pcw, pcs,
                                    input logic as_, bs, input logic [1:0] wb,
                                    input logic ret, trp, input logic [1:0] cs);
    return {imr, irw, dmr, dmw, rfw, pcw, pcs, as_, bs, wb, ret, trp, cs};
  endfunction

  function automatic int kind(input logic [6:0] op);
    case (op)
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b1100011: return K_BRANCH;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0010011: return K_ALUI;
      7'b0110011: return K_ALU;
      7'b0001111: return K_FENCE;
      default:    return K_ILL;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic push(input logic ia, input logic da, input logic [14:0] e, input string tag);
    step_t s;
    s.ia = ia; s.da = da; s.exp = e; s.tag = tag;
    steps.push_back(s);
  endtask

  task automatic add_trap(input logic [1:0] cause, input int n);
    for (int i = 0; i < n; i++)
      push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, cause), "trap");
  endtask

  // Expected per-cycle trace of one instruction from latency/handshake rules
  task automatic build(input logic [6:0] op, input int iw, input int dw, input logic tk,
                       input int ntrap, output bit trapped);
    int k, nf, nm;
    logic ack, as_, bs, st, fin, pcs;
    logic [1:0] wb;
    steps.delete();
    trapped = 1'b0;
    k  = kind(op);
    nf = (iw >= TO) ? TO : iw + 1;
    for (int w = 0; w < nf; w++) begin
      ack = (iw < TO) && (w == iw);
      push(ack, 1'b0, v(1, ack, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0), "fetch");
    end
    if (iw >= TO) begin add_trap(2'd2, ntrap); trapped = 1'b1; return; end
    push(1'b0, 1'b0, 15'd0, "decode");
    if (k == K_ILL) begin add_trap(2'd1, ntrap); trapped = 1'b1; return; end
    as_ = (k == K_AUIPC) || (k == K_JAL) || (k == K_BRANCH);
    bs  = (k != K_ALU);
    if (k == K_BRANCH)
      push(1'b0, 1'b0, v(0, 0, 0, 0, 0, 1, tk, as_, bs, 2'd0, 1, 0, 2'd0), "exec_br");
    else if (k == K_FENCE)
      push(1'b0, 1'b0, v(0, 0, 0, 0, 0, 1, 0, as_, bs, 2'd0, 1, 0, 2'd0), "exec_fence");
    else
      push(1'b0, 1'b0, v(0, 0, 0, 0, 0, 0, 0, as_, bs, 2'd0, 0, 0, 2'd0), "exec");
    if (k == K_BRANCH || k == K_FENCE) return;
    if (k == K_LOAD || k == K_STORE) begin
      st = (k == K_STORE);
      nm = (dw >= TO) ? TO : dw + 1;
      for (int m = 0; m < nm; m++) begin
        ack = (dw < TO) && (m == dw);
        fin = ack && st;
        push(1'b0, ack, v(0, 0, 1, st, 0, fin, 0, as_, bs, 2'd0, fin, 0, 2'd0), "mem");
      end
      if (dw >= TO) begin add_trap(2'd3, ntrap); trapped = 1'b1; return; end
      if (st) return;
    end
    wb  = (k == K_LOAD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : (k == K_LUI) ? 2'd3 : 2'd0;
    pcs = (k == K_JAL) || (k == K_JALR);
    push(1'b0, 1'b0, v(0, 0, 0, 0, 1, 1, pcs, as_, bs, wb, 1, 0, 2'd0), "wb");
  endtask

  // Called at a negedge; drives each step, checks #1 later, ends at a negedge
  task automatic play(input logic [6:0] op, input logic tk, input int limit);
    for (int i = 0; i < steps.size() && i < limit; i++) begin
      opcode = op; branch_taken = tk;
      imem_ack = steps[i].ia; dmem_ack = steps[i].da;
      #1;
      chk($sformatf("%s[%0d] op=%b", steps[i].tag, i, op), act, steps[i].exp);
      @(negedge clk);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1 chk("reset", act, 15'd0);
    @(negedge clk);
    imem_ack = 1'b1;
    #1 chk("reset_ack", act, 15'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run(input logic [6:0] op, input int iw, input int dw, input logic tk,
                     input int ntrap);
    bit tr;
    build(op, iw, dw, tk, ntrap, tr);
    play(op, tk, 1000);
    if (tr) do_reset();
  endtask

  initial begin
    bit tr;
    logic [6:0] op;
    legal_ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                  7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};
    @(negedge clk);
    do_reset();
    // ADDI, zero wait
    run(7'b0010011, 0, 0, 1'b0, 3);
    // LW with dmem_ack after 3 wait cycles
    run(7'b0000011, 0, 3, 1'b0, 3);
    // BEQ taken, then not taken
    run(7'b1100011, 0, 0, 1'b1, 3);
    run(7'b1100011, 1, 0, 1'b0, 3);
    // Illegal opcode, trap held for many cycles
    run(7'b1111111, 0, 0, 1'b0, 22);
    // Fetch timeout, then ack on the last allowed wait cycle
    run(7'b0110011, TO, 0, 1'b0, 4);
    run(7'b0110011, TO - 1, 0, 1'b0, 3);
    // Data timeout, and store with ack on the last allowed cycle
    run(7'b0100011, 0, TO, 1'b0, 4);
    run(7'b0100011, 0, TO - 1, 1'b0, 3);
    // Jumps, LUI
    run(7'b1101111, 0, 0, 1'b0, 3);
    run(7'b1100111, 2, 0, 1'b0, 3);
    run(7'b0110111, 0, 0, 1'b0, 3);
    // Reset while a load is waiting in MEM
    build(7'b0000011, 0, 3, 1'b0, 3, tr);
    play(7'b0000011, 1'b0, 3);
    #1 chk("mem_before_rst", act, v(0, 0, 1, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 2'd0));
    rst_n = 1'b0;
    #1 chk("mem_async_rst", act, 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("after_rst", act, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0));
    @(negedge clk);
    do_reset();
    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 9)];
      else op = 7'($urandom_range(0, 127));
      run(op, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
          1'($urandom_range(0, 1)), 3);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
